id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
DLX instruction-decode pipeline stage. It sits between the IF/ID register and the EX stage, and directly drives the register bank's read ports. It decodes the instruction, resolves operands with EX/MEM/WB forwarding, detects load-use hazards (stall plus bubble), and registers the result into the ID/EX pipeline register.

Parameters:
DATA_WIDTH, 32, datapath width.
ADDRESS_WIDTH, 5, register index width (32 registers; r0 hard-wired to zero).
PC_WIDTH, 32, program counter width.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
if_valid  input  1  IF/ID holds a valid instruction
if_instruction  input  32  instruction word
if_pc  input  PC_WIDTH  PC of instruction
id_stall  output  1  combinational; IF/ID must hold contents this cycle
flush  input  1  branch taken; discard instruction in decode
ex_stall  input  1  EX cannot accept; hold ID/EX register
read_address_1  output  ADDRESS_WIDTH  register bank port 1 (= rs1)
read_address_2  output  ADDRESS_WIDTH  register bank port 2 (= rs2)
read_data_1  input  DATA_WIDTH  bank data port 1
read_data_2  input  DATA_WIDTH  bank data port 2
ex_rd, mem_rd, wb_rd  input  ADDRESS_WIDTH  destination of instruction in that stage
ex_reg_write, mem_reg_write, wb_reg_write  input  1  that stage writes a register
ex_is_load  input  1  EX holds a load
ex_result, mem_result, wb_result  input  DATA_WIDTH  forwardable value per stage
id_valid  output  1  ID/EX contents valid
id_opcode  output  6  opcode; id_func  output  6  R-type function
id_rd  output  ADDRESS_WIDTH  destination register
id_reg_write  output  1  instruction writes a register
id_is_load, id_is_store  output  1  memory-class flags
id_operand_a, id_operand_b  output  DATA_WIDTH  resolved rs1/rs2 values
id_immediate  output  DATA_WIDTH  extended immediate
id_pc  output  PC_WIDTH  PC of instruction

Behaviour:
- Reset: all registered outputs 0, id_valid=0, FSM=NORMAL.
- Field decode:
  - opcode=[31:26], rs1=[25:21], rs2=[20:16].
  - R-type (opcode 0x00): rd=[15:11], func=[5:0].
  - I-type: rd=[20:16].
  - JAL (0x03): rd=31.
  - J (0x02), stores (opcode[5:3]=3'b101) and branches (0x04/0x05): reg_write=0.
  - load: opcode[5:3]=3'b100.
  - rd=0 forces reg_write=0.
- Immediate:
  - J/JAL: sign-extend [25:0].
  - andi/ori/xori (0x0C–0x0E): zero-extend [15:0].
  - Otherwise: sign-extend [15:0].
- Operand resolution, per source, combinational, priority order:
  1. source==0 → 0.
  2. EX match (ex_reg_write, ex_rd==src, !ex_is_load) → ex_result.
  3. MEM match → mem_result.
  4. WB match → wb_result (covers same-cycle bank write).
  5. Otherwise bank data.
- Load-use hazard: if_valid && ex_is_load && ex_reg_write && ex_rd!=0 && ex_rd ∈ {rs1, rs2 used}.
  - rs2 counts as used for R-type, stores and branches only.
- FSM:
  - NORMAL: on hazard (and !ex_stall, !flush) assert id_stall, load bubble (id_valid=0), go to LOAD_STALL.
  - LOAD_STALL: no stall for this instruction (the load is now in MEM and is forwarded); capture the instruction, return to NORMAL.
  - At most one stall cycle per load.
- ex_stall=1: ID/EX register holds and id_stall=1. ex_stall has priority over hazard bubbling; the FSM state holds.
- flush=1 (and !ex_stall): load bubble, id_stall=0, FSM→NORMAL. Flush wins over hazard.
- Normal capture: ID/EX loads decoded fields, id_valid=if_valid. Latency is 1 cycle.
- Invalid input: id_valid=0; other fields are don't-care but must be loaded deterministically.
- Reset mid-stall returns to NORMAL with a bubble.

Decomposition:
- Shared package dlx_pkg: opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQZ, OP_BNEZ, OP_ANDI, OP_ORI, OP_XORI), load/store class masks, FSM state encoding, LINK_REGISTER=31.
- One sub-module, forward_mux: a single operand's zero/EX/MEM/WB/bank priority select. Instantiate it twice.

Test Plan:
- add r3,r1,r2 with bank r1=5, r2=7, no hazards → next cycle id_valid=1, id_operand_a=5, id_operand_b=7, id_rd=3, id_reg_write=1.
- EX writes r1=0x10, MEM writes r1=0x20, bank r1=5 → operand_a=0x10. Drop the EX match → 0x20. WB-only match with 0x30 → 0x30.
- lw r4 in EX, then add r5,r4,r0 → id_stall=1 for 1 cycle, one bubble (id_valid=0); next cycle operand_a=mem_result 0xBEEF, id_valid=1.
- addi r2,r0,-1 → id_immediate=0xFFFFFFFF. ori r2,r0,0xFFFF → 0x0000FFFF. jal → id_rd=31, immediate is the sign-extended 26-bit offset.
- flush asserted during a load-use hazard → bubble, id_stall=0, FSM NORMAL. ex_stall held 3 cycles → ID/EX outputs unchanged, id_stall=1.
- Write to r0 with a forwarded nonzero value → operand=0, reg_write=0. Reset asserted mid-stall → all outputs 0.

Source files
------------

// File: rtl/dlx_pkg.sv
// DLX shared decode definitions: opcodes, class masks, ID state encoding.
// Also provides the field decoder used by the decode stage.
package dlx_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [2:0] LOAD_CLASS  = 3'b100;
  localparam logic [2:0] STORE_CLASS = 3'b101;

  localparam logic [4:0] LINK_REGISTER = 5'd31;

  typedef enum logic {
    ST_NORMAL     = 1'b0,
    ST_LOAD_STALL = 1'b1
  } id_state_e;

  typedef struct packed {
    logic [5:0] opcode;
    logic [5:0] func;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       is_load;
    logic       is_store;
    logic       rs2_used;
    logic       is_jump;
    logic       zext;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    logic is_r;
    logic is_jal;
    logic is_br;
    d.opcode   = ins[31:26];
    d.rs1      = ins[25:21];
    d.rs2      = ins[20:16];
    is_r       = (d.opcode == OP_RTYPE);
    is_jal     = (d.opcode == OP_JAL);
    is_br      = (d.opcode == OP_BEQZ) ||
                 (d.opcode == OP_BNEZ);
    d.is_jump  = (d.opcode == OP_J) || is_jal;
    d.zext     = (d.opcode == OP_ANDI) ||
                 (d.opcode == OP_ORI)  ||
                 (d.opcode == OP_XORI);
    d.is_load  = (d.opcode[5:3] == LOAD_CLASS);
    d.is_store = (d.opcode[5:3] == STORE_CLASS);
    d.func     = is_r ? ins[5:0] : 6'd0;
    unique case (1'b1)
      is_r:    d.rd = ins[15:11];
      is_jal:  d.rd = LINK_REGISTER;
      default: d.rd = ins[20:16];
    endcase
    d.rs2_used  = is_r || d.is_store || is_br;
    d.reg_write = !((d.opcode == OP_J) ||
                    d.is_store || is_br) &&
                  (d.rd != 5'd0);
    return d;
  endfunction

endpackage

// File: rtl/id_stage_forward_mux.sv
// Single-operand bypass select: zero register, then EX, MEM, WB,
// and finally the register bank value.
module forward_mux #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] src_i,
  input  logic          ex_we_i,
  input  logic [AW-1:0] ex_rd_i,
  input  logic          ex_load_i,
  input  logic [DW-1:0] ex_data_i,
  input  logic          mem_we_i,
  input  logic [AW-1:0] mem_rd_i,
  input  logic [DW-1:0] mem_data_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_rd_i,
  input  logic [DW-1:0] wb_data_i,
  input  logic [DW-1:0] bank_i,
  output logic [DW-1:0] data_o
);

  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  // A load in EX has no value yet; it is handled by the stall.
  assign hit_ex  = ex_we_i && (ex_rd_i == src_i) &&
                   !ex_load_i;
  assign hit_mem = mem_we_i && (mem_rd_i == src_i);
  assign hit_wb  = wb_we_i && (wb_rd_i == src_i);

  always_comb begin
    data_o = bank_i;
    if (src_i == '0) begin
      data_o = '0;
    end else if (hit_ex) begin
      data_o = ex_data_i;
    end else if (hit_mem) begin
      data_o = mem_data_i;
    end else if (hit_wb) begin
      data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_stage.sv
// DLX decode stage: field decode, operand bypass, load-use stall,
// and the ID/EX pipeline register.
module id_stage
  import dlx_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int PC_WIDTH      = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     if_valid,
  input  logic [31:0]              if_instruction,
  input  logic [PC_WIDTH-1:0]      if_pc,
  output logic                     id_stall,
  input  logic                     flush,
  input  logic                     ex_stall,
  output logic [ADDRESS_WIDTH-1:0] read_address_1,
  output logic [ADDRESS_WIDTH-1:0] read_address_2,
  input  logic [DATA_WIDTH-1:0]    read_data_1,
  input  logic [DATA_WIDTH-1:0]    read_data_2,
  input  logic [ADDRESS_WIDTH-1:0] ex_rd,
  input  logic [ADDRESS_WIDTH-1:0] mem_rd,
  input  logic [ADDRESS_WIDTH-1:0] wb_rd,
  input  logic                     ex_reg_write,
  input  logic                     mem_reg_write,
  input  logic                     wb_reg_write,
  input  logic                     ex_is_load,
  input  logic [DATA_WIDTH-1:0]    ex_result,
  input  logic [DATA_WIDTH-1:0]    mem_result,
  input  logic [DATA_WIDTH-1:0]    wb_result,
  output logic                     id_valid,
  output logic [5:0]               id_opcode,
  output logic [5:0]               id_func,
  output logic [ADDRESS_WIDTH-1:0] id_rd,
  output logic                     id_reg_write,
  output logic                     id_is_load,
  output logic                     id_is_store,
  output logic [DATA_WIDTH-1:0]    id_operand_a,
  output logic [DATA_WIDTH-1:0]    id_operand_b,
  output logic [DATA_WIDTH-1:0]    id_immediate,
  output logic [PC_WIDTH-1:0]      id_pc
);

  dec_t                     dec;
  logic [ADDRESS_WIDTH-1:0] rs1;
  logic [ADDRESS_WIDTH-1:0] rs2;
  logic [ADDRESS_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0]    imm;
  logic [DATA_WIDTH-1:0]    opa;
  logic [DATA_WIDTH-1:0]    opb;
  logic                     load_in_ex;
  logic                     hazard;
  logic                     bubble;

  id_state_e                state_q;
  logic                     valid_q;
  logic                     rw_q;
  logic                     ld_q;
  logic                     st_q;
  logic [5:0]               opc_q;
  logic [5:0]               fn_q;
  logic [ADDRESS_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0]    opa_q;
  logic [DATA_WIDTH-1:0]    opb_q;
  logic [DATA_WIDTH-1:0]    imm_q;
  logic [PC_WIDTH-1:0]      pc_q;

  assign dec = decode(if_instruction);
  assign rs1 = ADDRESS_WIDTH'(dec.rs1);
  assign rs2 = ADDRESS_WIDTH'(dec.rs2);
  assign rd  = ADDRESS_WIDTH'(dec.rd);

  assign read_address_1 = rs1;
  assign read_address_2 = rs2;

  always_comb begin
    imm = DATA_WIDTH'($signed(if_instruction[15:0]));
    unique case (1'b1)
      dec.is_jump:
        imm = DATA_WIDTH'($signed(if_instruction[25:0]));
      dec.zext:
        imm = DATA_WIDTH'(if_instruction[15:0]);
      default: ;
    endcase
  end

  forward_mux #(
    .DW (DATA_WIDTH),
    .AW (ADDRESS_WIDTH)
  ) u_fwd_a (
    .src_i      (rs1),
    .ex_we_i    (ex_reg_write),
    .ex_rd_i    (ex_rd),
    .ex_load_i  (ex_is_load),
    .ex_data_i  (ex_result),
    .mem_we_i   (mem_reg_write),
    .mem_rd_i   (mem_rd),
    .mem_data_i (mem_result),
    .wb_we_i    (wb_reg_write),
    .wb_rd_i    (wb_rd),
    .wb_data_i  (wb_result),
    .bank_i     (read_data_1),
    .data_o     (opa)
  );

  forward_mux #(
    .DW (DATA_WIDTH),
    .AW (ADDRESS_WIDTH)
  ) u_fwd_b (
    .src_i      (rs2),
    .ex_we_i    (ex_reg_write),
    .ex_rd_i    (ex_rd),
    .ex_load_i  (ex_is_load),
    .ex_data_i  (ex_result),
    .mem_we_i   (mem_reg_write),
    .mem_rd_i   (mem_rd),
    .mem_data_i (mem_result),
    .wb_we_i    (wb_reg_write),
    .wb_rd_i    (wb_rd),
    .wb_data_i  (wb_result),
    .bank_i     (read_data_2),
    .data_o     (opb)
  );

  assign load_in_ex = ex_is_load && ex_reg_write &&
                      (ex_rd != '0);
  assign hazard = if_valid && load_in_ex &&
                  ((ex_rd == rs1) ||
                   (dec.rs2_used && (ex_rd == rs2)));
  // After one stall the load sits in MEM and is bypassed.
  assign bubble = (state_q == ST_NORMAL) && hazard;

  assign id_stall = ex_stall || (!flush && bubble);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_NORMAL;
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      opc_q   <= '0;
      fn_q    <= '0;
      rd_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
    end else if (!ex_stall) begin
      if (flush || bubble) begin
        state_q <= flush ? ST_NORMAL : ST_LOAD_STALL;
        valid_q <= 1'b0;
        rw_q    <= 1'b0;
        ld_q    <= 1'b0;
        st_q    <= 1'b0;
        opc_q   <= '0;
        fn_q    <= '0;
        rd_q    <= '0;
        opa_q   <= '0;
        opb_q   <= '0;
        imm_q   <= '0;
        pc_q    <= '0;
      end else begin
        state_q <= ST_NORMAL;
        valid_q <= if_valid;
        rw_q    <= if_valid && dec.reg_write;
        ld_q    <= if_valid && dec.is_load;
        st_q    <= if_valid && dec.is_store;
        opc_q   <= dec.opcode;
        fn_q    <= dec.func;
        rd_q    <= rd;
        opa_q   <= opa;
        opb_q   <= opb;
        imm_q   <= imm;
        pc_q    <= if_pc;
      end
    end
  end

  assign id_valid     = valid_q;
  assign id_reg_write = rw_q;
  assign id_is_load   = ld_q;
  assign id_is_store  = st_q;
  assign id_opcode    = opc_q;
  assign id_func      = fn_q;
  assign id_rd        = rd_q;
  assign id_operand_a = opa_q;
  assign id_operand_b = opb_q;
  assign id_immediate = imm_q;
  assign id_pc        = pc_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus a randomized run
// against an instruction-level reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        id_stall;
  logic        flush;
  logic        ex_stall;
  logic [4:0]  read_address_1;
  logic [4:0]  read_address_2;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_reg_write, mem_reg_write, wb_reg_write;
  logic        ex_is_load;
  logic [31:0] ex_result, mem_result, wb_result;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [5:0]  id_func;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_is_load;
  logic        id_is_store;
  logic [31:0] id_operand_a;
  logic [31:0] id_operand_b;
  logic [31:0] id_immediate;
  logic [31:0] id_pc;

  logic [31:0] regs [32];
  int errors = 0;
  int checks = 0;

  assign read_data_1 = regs[read_address_1];
  assign read_data_2 = regs[read_address_2];

  always #5 clk = ~clk;

  id_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .id_stall       (id_stall),
    .flush          (flush),
    .ex_stall       (ex_stall),
    .read_address_1 (read_address_1),
    .read_address_2 (read_address_2),
    .read_data_1    (read_data_1),
    .read_data_2    (read_data_2),
    .ex_rd          (ex_rd),
    .mem_rd         (mem_rd),
    .wb_rd          (wb_rd),
    .ex_reg_write   (ex_reg_write),
    .mem_reg_write  (mem_reg_write),
    .wb_reg_write   (wb_reg_write),
    .ex_is_load     (ex_is_load),
    .ex_result      (ex_result),
    .mem_result     (mem_result),
    .wb_result      (wb_result),
    .id_valid       (id_valid),
    .id_opcode      (id_opcode),
    .id_func        (id_func),
    .id_rd          (id_rd),
    .id_reg_write   (id_reg_write),
    .id_is_load     (id_is_load),
    .id_is_store    (id_is_store),
    .id_operand_a   (id_operand_a),
    .id_operand_b   (id_operand_b),
    .id_immediate   (id_immediate),
    .id_pc          (id_pc)
  );

  typedef struct {
    int          op;
    int          fn;
    int          rs1;
    int          rs2;
    int          rd;
    bit          rw;
    bit          ld;
    bit          st;
    bit          use2;
    logic [31:0] imm;
  } ref_t;

  function automatic logic [31:0] enc_r(int rs1, int rs2, int rd, int fn);
    return (32'(rs1) << 21) | (32'(rs2) << 16) |
           (32'(rd) << 11) | 32'(fn);
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs1, int rd, int imm);
    return (32'(op) << 26) | (32'(rs1) << 21) |
           (32'(rd) << 16) | (32'(imm) & 32'hFFFF);
  endfunction

  function automatic logic [31:0] enc_j(int op, int off);
    return (32'(op) << 26) | (32'(off) & 32'h03FF_FFFF);
  endfunction

  function automatic ref_t ref_decode(logic [31:0] w);
    ref_t r;
    int v;
    r.op  = int'(w >> 26);
    r.rs1 = int'((w >> 21) % 32);
    r.rs2 = int'((w >> 16) % 32);
    if (r.op == 0) r.rd = int'((w >> 11) % 32);
    else if (r.op == 3) r.rd = 31;
    else r.rd = r.rs2;
    r.fn   = (r.op == 0) ? int'(w % 64) : 0;
    r.ld   = (r.op / 8) == 4;
    r.st   = (r.op / 8) == 5;
    r.use2 = (r.op == 0) || r.st || (r.op == 4) || (r.op == 5);
    r.rw   = !((r.op == 2) || r.st || (r.op == 4) || (r.op == 5)) &&
             (r.rd != 0);
    if (r.op == 2 || r.op == 3) begin
      v = int'(w % (1 << 26));
      if (v >= (1 << 25)) v = v - (1 << 26);
      r.imm = 32'(v);
    end else if (r.op >= 12 && r.op <= 14) begin
      r.imm = w % 65536;
    end else begin
      v = int'(w % 65536);
      if (v >= 32768) v = v - 65536;
      r.imm = 32'(v);
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_operand(int src);
    if (src == 0) return 32'd0;
    if (ex_reg_write && int'(ex_rd) == src && !ex_is_load) return ex_result;
    if (mem_reg_write && int'(mem_rd) == src) return mem_result;
    if (wb_reg_write && int'(wb_rd) == src) return wb_result;
    return regs[src];
  endfunction

  function automatic bit ref_hazard(ref_t d);
    return if_valid && ex_is_load && ex_reg_write && ex_rd != 0 &&
           (int'(ex_rd) == d.rs1 || (d.use2 && int'(ex_rd) == d.rs2));
  endfunction

  task automatic clear_inputs();
    if_valid = 0; if_instruction = 0; if_pc = 0;
    flush = 0; ex_stall = 0;
    ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_reg_write = 0; mem_reg_write = 0; wb_reg_write = 0;
    ex_is_load = 0;
    ex_result = 0; mem_result = 0; wb_result = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear_inputs();
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + 32'(i);
    regs[0] = 0;
    rst_n = 0;
    #12;
    checks++;
    if ({id_valid, id_opcode, id_func, id_rd, id_reg_write, id_is_load,
         id_is_store, id_operand_a, id_operand_b, id_immediate,
         id_pc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b a=%h imm=%h pc=%h, want all 0",
               id_valid, id_operand_a, id_immediate, id_pc);
    end
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b want 0", id_stall);
    end
    #1 rst_n = 1;
    step();
  endtask

  task automatic test_add();
    idle();
    regs[1] = 5; regs[2] = 7;
    if_valid = 1; if_pc = 32'h100;
    if_instruction = enc_r(1, 2, 3, 32);
    step();
    checks++;
    if ({id_valid, id_rd, id_reg_write, id_operand_a, id_operand_b, id_pc} !==
        {1'b1, 5'd3, 1'b1, 32'd5, 32'd7, 32'h100}) begin
      errors++;
      $display("FAIL add: got v=%b rd=%0d rw=%b a=%0d b=%0d pc=%h, want 1 3 1 5 7 100",
               id_valid, id_rd, id_reg_write, id_operand_a, id_operand_b, id_pc);
    end
    checks++;
    if ({id_opcode, id_func, id_is_load, id_is_store} !== {6'd0, 6'd32, 2'b00}) begin
      errors++;
      $display("FAIL add_fields: got op=%h fn=%h ld=%b st=%b, want 0 20 0 0",
               id_opcode, id_func, id_is_load, id_is_store);
    end
  endtask

  task automatic test_forward();
    idle();
    regs[1] = 5; regs[2] = 7;
    if_valid = 1;
    if_instruction = enc_r(1, 2, 3, 32);
    ex_reg_write = 1; ex_rd = 1; ex_result = 32'h10;
    mem_reg_write = 1; mem_rd = 1; mem_result = 32'h20;
    step();
    checks++;
    if (id_operand_a !== 32'h10) begin
      errors++;
      $display("FAIL fwd_ex: got %h want 10", id_operand_a);
    end
    ex_reg_write = 0;
    step();
    checks++;
    if (id_operand_a !== 32'h20) begin
      errors++;
      $display("FAIL fwd_mem: got %h want 20", id_operand_a);
    end
    mem_reg_write = 0;
    wb_reg_write = 1; wb_rd = 1; wb_result = 32'h30;
    step();
    checks++;
    if ({id_operand_a, id_operand_b} !== {32'h30, 32'd7}) begin
      errors++;
      $display("FAIL fwd_wb: got a=%h b=%h want 30 7", id_operand_a, id_operand_b);
    end
  endtask

  task automatic test_load_use();
    idle();
    regs[4] = 32'h1111;
    if_valid = 1;
    if_instruction = enc_r(4, 0, 5, 32);
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 4;
    #1;
    checks++;
    if (id_stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall: got %b want 1", id_stall);
    end
    step();
    checks++;
    if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL lu_bubble: got valid=%b want 0", id_valid);
    end
    mem_reg_write = 1; mem_rd = 4; mem_result = 32'hBEEF;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_one_stall: got %b want 0", id_stall);
    end
    step();
    checks++;
    if ({id_valid, id_operand_a, id_rd} !== {1'b1, 32'hBEEF, 5'd5}) begin
      errors++;
      $display("FAIL lu_capture: got v=%b a=%h rd=%0d want 1 beef 5",
               id_valid, id_operand_a, id_rd);
    end
  endtask

  task automatic test_immediates();
    idle();
    if_valid = 1;
    if_instruction = enc_i(8, 0, 2, -1);
    step();
    checks++;
    if ({id_immediate, id_rd, id_reg_write} !== {32'hFFFF_FFFF, 5'd2, 1'b1}) begin
      errors++;
      $display("FAIL imm_addi: got imm=%h rd=%0d rw=%b want ffffffff 2 1",
               id_immediate, id_rd, id_reg_write);
    end
    if_instruction = enc_i(13, 0, 2, 32'hFFFF);
    step();
    checks++;
    if (id_immediate !== 32'h0000_FFFF) begin
      errors++;
      $display("FAIL imm_ori: got %h want 0000ffff", id_immediate);
    end
    if_instruction = enc_j(3, 32'h03FF_FFF0);
    step();
    checks++;
    if ({id_immediate, id_rd, id_reg_write} !== {32'hFFFF_FFF0, 5'd31, 1'b1}) begin
      errors++;
      $display("FAIL imm_jal: got imm=%h rd=%0d rw=%b want fffffff0 31 1",
               id_immediate, id_rd, id_reg_write);
    end
    if_instruction = enc_j(2, 32'h123);
    step();
    checks++;
    if ({id_immediate, id_reg_write} !== {32'h123, 1'b0}) begin
      errors++;
      $display("FAIL imm_j: got imm=%h rw=%b want 123 0", id_immediate, id_reg_write);
    end
  endtask

  task automatic test_flush();
    idle();
    if_valid = 1;
    if_instruction = enc_r(4, 0, 5, 32);
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 4;
    flush = 1;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b want 0", id_stall);
    end
    step();
    checks++;
    if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_bubble: got valid=%b want 0", id_valid);
    end
    flush = 0;
    #1;
    checks++;
    if (id_stall !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: got stall=%b want 1", id_stall);
    end
  endtask

  task automatic test_ex_stall();
    idle();
    regs[1] = 5; regs[2] = 7;
    if_valid = 1;
    if_instruction = enc_r(1, 2, 3, 32);
    step();
    ex_stall = 1;
    if_instruction = enc_r(2, 1, 9, 34);
    if_pc = 32'h200;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (id_stall !== 1'b1) begin
        errors++;
        $display("FAIL exstall_stall: cycle %0d got %b want 1", i, id_stall);
      end
      step();
      checks++;
      if ({id_valid, id_rd, id_operand_a, id_operand_b} !==
          {1'b1, 5'd3, 32'd5, 32'd7}) begin
        errors++;
        $display("FAIL exstall_hold: cycle %0d got v=%b rd=%0d a=%0d b=%0d want 1 3 5 7",
                 i, id_valid, id_rd, id_operand_a, id_operand_b);
      end
    end
  endtask

  task automatic test_r0();
    idle();
    if_valid = 1;
    if_instruction = enc_r(0, 0, 0, 32);
    ex_reg_write = 1; ex_rd = 0; ex_result = 32'h55;
    mem_reg_write = 1; mem_rd = 0; mem_result = 32'h66;
    step();
    checks++;
    if ({id_valid, id_operand_a, id_operand_b, id_reg_write} !==
        {1'b1, 32'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL r0: got v=%b a=%h b=%h rw=%b want 1 0 0 0",
               id_valid, id_operand_a, id_operand_b, id_reg_write);
    end
  endtask

  task automatic test_reset_mid_stall();
    idle();
    if_valid = 1;
    if_instruction = enc_r(4, 0, 5, 32);
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 4;
    step();
    #2 rst_n = 0;
    #1;
    checks++;
    if ({id_valid, id_operand_a, id_rd, id_pc} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got v=%b a=%h rd=%0d pc=%h want 0",
               id_valid, id_operand_a, id_rd, id_pc);
    end
    rst_n = 1;
    #1;
    checks++;
    if (id_stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_state: got stall=%b want 1", id_stall);
    end
  endtask

  task automatic test_random();
    int ops [11] = '{0, 2, 3, 4, 5, 8, 12, 13, 14, 35, 43};
    bit stalled = 0;
    bit ev = 0, erw = 0, eld = 0, est = 0;
    logic [5:0] eop = 0, efn = 0;
    logic [4:0] erd = 0;
    logic [31:0] ea = 0, eb = 0, eimm = 0, epc = 0;
    logic [31:0] w;
    ref_t d;
    bit hz, xs;
    clear_inputs();
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    #2 rst_n = 0;
    #2 rst_n = 1;
    step();
    for (int n = 0; n < 400; n++) begin
      w = $urandom;
      w[31:26] = 6'(ops[$urandom_range(0, 10)]);
      w[25:21] = 5'($urandom_range(0, 3));
      w[20:16] = 5'($urandom_range(0, 3));
      w[15:11] = 5'($urandom_range(0, 3));
      if_instruction = w;
      if_valid = ($urandom_range(0, 7) != 0);
      if_pc = $urandom;
      flush = ($urandom_range(0, 9) == 0);
      ex_stall = ($urandom_range(0, 7) == 0);
      ex_rd = 5'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      ex_reg_write = ($urandom_range(0, 9) < 7);
      mem_reg_write = $urandom_range(0, 1) == 1;
      wb_reg_write = $urandom_range(0, 1) == 1;
      ex_is_load = ($urandom_range(0, 9) < 4);
      ex_result = $urandom; mem_result = $urandom; wb_result = $urandom;
      #1;
      d = ref_decode(w);
      hz = ref_hazard(d);
      xs = ex_stall || (!flush && !stalled && hz);
      checks++;
      if ({id_stall, read_address_1, read_address_2} !==
          {xs, 5'(d.rs1), 5'(d.rs2)}) begin
        errors++;
        $display("FAIL rand_comb: n=%0d got stall=%b ra1=%0d ra2=%0d want %b %0d %0d",
                 n, id_stall, read_address_1, read_address_2, xs, d.rs1, d.rs2);
      end
      if (ex_stall) begin
      end else if (flush || (!stalled && hz)) begin
        ev = 0; erw = 0; eld = 0; est = 0;
        stalled = !flush;
      end else begin
        ev = if_valid;
        erw = if_valid && d.rw;
        eld = if_valid && d.ld;
        est = if_valid && d.st;
        eop = 6'(d.op); efn = 6'(d.fn); erd = 5'(d.rd);
        ea = ref_operand(d.rs1);
        eb = ref_operand(d.rs2);
        eimm = d.imm; epc = if_pc;
        stalled = 0;
      end
      step();
      checks++;
      if ({id_valid, id_reg_write, id_is_load, id_is_store} !==
          {ev, erw, eld, est}) begin
        errors++;
        $display("FAIL rand_flags: n=%0d got %b%b%b%b want %b%b%b%b", n,
                 id_valid, id_reg_write, id_is_load, id_is_store, ev, erw, eld, est);
      end
      if (ev) begin
        checks++;
        if ({id_opcode, id_func, id_rd, id_operand_a, id_operand_b,
             id_immediate, id_pc} !== {eop, efn, erd, ea, eb, eimm, epc}) begin
          errors++;
          $display("FAIL rand_data: n=%0d got op=%h fn=%h rd=%0d a=%h b=%h imm=%h pc=%h want %h %h %0d %h %h %h %h",
                   n, id_opcode, id_func, id_rd, id_operand_a, id_operand_b,
                   id_immediate, id_pc, eop, efn, erd, ea, eb, eimm, epc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_load_use();
    test_immediates();
    test_flush();
    test_ex_stall();
    test_r0();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
